// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: bus command encoding, tag-table entry type and table size
package mem_bus_ctrl_pkg;
  localparam int MEM_TAGS = 16;
  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} BUS_COMMAND;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} MEM_OWNER;
  typedef struct packed {
    logic       valid;
    MEM_OWNER   owner;
    logic [31:0] addr;
  } MEM_TAG_ENTRY;
endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: 16-entry tag-indexed record of in-flight loads (one alloc port, one read+clear port)
module mem_tag_table
  import mem_bus_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [3:0]          alloc_tag,
  input  MEM_OWNER            alloc_owner,
  input  logic [31:0]         alloc_addr,
  input  logic [3:0]          ret_tag,
  output logic                ret_hit,
  output MEM_OWNER            ret_owner,
  output logic [31:0]         ret_addr,
  output logic [MEM_TAGS-1:0] valid_vec,
  output logic [3:0]          count
);
  MEM_TAG_ENTRY entry_q [MEM_TAGS];
  MEM_TAG_ENTRY entry_d [MEM_TAGS];
  assign ret_hit   = (ret_tag != 4'd0) && entry_q[ret_tag].valid;
  assign ret_owner = entry_q[ret_tag].owner;
  assign ret_addr  = entry_q[ret_tag].addr;
  // clear the returning tag first so a same-tag allocate in the same cycle wins
  always_comb begin
    entry_d = entry_q;
    if (ret_hit) entry_d[ret_tag].valid = 1'b0;
    if (alloc_en) entry_d[alloc_tag] = {1'b1, alloc_owner, alloc_addr};
  end
  // valid vector and popcount; tag 0 means "no tag" on the bus so it is never counted
  always_comb begin
    valid_vec = '0;
    count = '0;
    for (int i = 1; i < MEM_TAGS; i++) begin
      valid_vec[i] = entry_q[i].valid;
      count = count + 4'(entry_q[i].valid);
    end
  end
  // table state; reset drops every in-flight entry
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < MEM_TAGS; i++) entry_q[i] <= '0;
    else entry_q <= entry_d;
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: icache/dcache arbiter onto the tagged memory bus with tag-routed returns (optional MEM_BUS_STATS_EN counters)
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 15,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dc_req_valid,
  input  logic [1:0]  dc_req_cmd,
  input  logic [31:0] dc_req_addr,
  input  logic [63:0] dc_req_data,
  output logic        dc_req_ready,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_req_ready,
  output logic        dc_resp_valid,
  output logic [31:0] dc_resp_addr,
  output logic [63:0] dc_resp_data,
  output logic        ic_resp_valid,
  output logic [31:0] ic_resp_addr,
  output logic [63:0] ic_resp_data,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        stray_tag_err
`ifdef MEM_BUS_STATS_EN
  ,
  output logic [63:0] stat_loads,
  output logic [63:0] stat_stores,
  output logic [63:0] stat_busy_cycles
`endif
);
  logic [7:0] starve_q, starve_d;
  logic stray_q, stray_d;
  logic full, dc_store, dc_load, ic_load, sel_ic, sel_dc, accept, alloc_en, collide, ret_hit;
  logic [3:0] count;
  logic [MEM_TAGS-1:0] valid_vec;
  MEM_OWNER ret_owner;
  logic [31:0] ret_addr;
  mem_tag_table u_tags (
    .clock(clock), .reset(reset),
    .alloc_en(alloc_en), .alloc_tag(mem2proc_response),
    .alloc_owner(sel_ic ? OWN_IC : OWN_DC), .alloc_addr(proc2mem_addr),
    .ret_tag(mem2proc_tag), .ret_hit(ret_hit), .ret_owner(ret_owner), .ret_addr(ret_addr),
    .valid_vec(valid_vec), .count(count)
  );
  // arbitration: store > dc load > ic load, ic forced once starved; loads blocked when the table is full
  always_comb begin
    full = int'(count) >= MAX_OUTSTANDING;
    dc_store = dc_req_valid && dc_req_cmd == BUS_STORE;
    dc_load = dc_req_valid && dc_req_cmd == BUS_LOAD && !full;
    ic_load = ic_req_valid && !full;
    sel_ic = ic_load && (int'(starve_q) >= STARVE_LIMIT || !(dc_store || dc_load));
    sel_dc = !sel_ic && (dc_store || dc_load);
    accept = mem2proc_response != 4'd0;
    dc_req_ready = sel_dc && accept;
    ic_req_ready = sel_ic && accept;
    proc2mem_command = sel_ic ? BUS_LOAD : sel_dc ? (dc_store ? BUS_STORE : BUS_LOAD) : BUS_NONE;
    proc2mem_addr = sel_ic ? ic_req_addr : sel_dc ? dc_req_addr : '0;
    proc2mem_data = (sel_dc && dc_store) ? dc_req_data : '0;
    alloc_en = accept && (sel_ic || (sel_dc && !dc_store));
    collide = alloc_en && valid_vec[mem2proc_response] && !(ret_hit && mem2proc_tag == mem2proc_response);
  end
  assign dc_resp_valid = ret_hit && ret_owner == OWN_DC;
  assign ic_resp_valid = ret_hit && ret_owner == OWN_IC;
  assign dc_resp_addr = ret_addr;
  assign ic_resp_addr = ret_addr;
  assign dc_resp_data = mem2proc_data;
  assign ic_resp_data = mem2proc_data;
  assign stray_tag_err = stray_q;
  // starve counter saturates while ic is refused; stray error is sticky on unmatched return or tag reuse
  always_comb begin
    starve_d = (ic_req_valid && !ic_req_ready) ? (starve_q == 8'hff ? starve_q : starve_q + 8'd1) : 8'd0;
    stray_d = stray_q || (mem2proc_tag != 4'd0 && !ret_hit) || collide;
  end
  // control state registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      starve_q <= '0;
      stray_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stray_q <= stray_d;
    end
`ifdef MEM_BUS_STATS_EN
  logic [63:0] loads_q, loads_d, stores_q, stores_d, busy_q, busy_d;
  // counts accepted loads, accepted stores and cycles where memory refused the issued request
  always_comb begin
    loads_d = loads_q + 64'(alloc_en);
    stores_d = stores_q + 64'(accept && sel_dc && dc_store);
    busy_d = busy_q + 64'((sel_ic || sel_dc) && !accept);
  end
  // statistics registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      loads_q <= '0;
      stores_q <= '0;
      busy_q <= '0;
    end else begin
      loads_q <= loads_d;
      stores_q <= stores_d;
      busy_q <= busy_d;
    end
  assign stat_loads = loads_q;
  assign stat_stores = stores_q;
  assign stat_busy_cycles = busy_q;
`endif
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of arbitration, tag bookkeeping, returns and stray-tag handling
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic dc_req_valid, dc_req_ready, ic_req_valid, ic_req_ready;
  logic [1:0] dc_req_cmd, proc2mem_command;
  logic [31:0] dc_req_addr, ic_req_addr, dc_resp_addr, ic_resp_addr, proc2mem_addr;
  logic [63:0] dc_req_data, dc_resp_data, ic_resp_data, proc2mem_data, mem2proc_data;
  logic dc_resp_valid, ic_resp_valid, stray_tag_err;
  logic [3:0] mem2proc_response, mem2proc_tag;
`ifdef MEM_BUS_STATS_EN
  logic [63:0] stat_loads, stat_stores, stat_busy_cycles;
`endif
  int total = 0;
  int bad = 0;
  mem_bus_ctrl dut (
    .clock(clock), .reset(reset),
    .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_addr(dc_resp_addr), .dc_resp_data(dc_resp_data),
    .ic_resp_valid(ic_resp_valid), .ic_resp_addr(ic_resp_addr), .ic_resp_data(ic_resp_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .stray_tag_err(stray_tag_err)
`ifdef MEM_BUS_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_busy_cycles(stat_busy_cycles)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    dc_req_valid = 1'b0; dc_req_cmd = BUS_NONE; dc_req_addr = '0; dc_req_data = '0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic dc(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data);
    dc_req_valid = 1'b1; dc_req_cmd = cmd; dc_req_addr = addr; dc_req_data = data;
  endtask
  initial begin
    idle();
    #1 reset = 1'b1;
    #1;
    chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_dc_ready", 64'(dc_req_ready), 0);
    chk("rst_ic_ready", 64'(ic_req_ready), 0);
    chk("rst_dc_resp", 64'(dc_resp_valid), 0);
    chk("rst_ic_resp", 64'(ic_resp_valid), 0);
    chk("rst_stray", 64'(stray_tag_err), 0);
    cyc();
    reset = 1'b0;
    // 1: dc load, return two cycles later
    dc(BUS_LOAD, 32'h100, 0); mem2proc_response = 4'd3; #1;
    chk("t1_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("t1_addr", 64'(proc2mem_addr), 64'h100);
    chk("t1_dc_ready", 64'(dc_req_ready), 1);
    chk("t1_ic_ready", 64'(ic_req_ready), 0);
    cyc(); idle(); cyc();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD; #1;
    chk("t1_resp_valid", 64'(dc_resp_valid), 1);
    chk("t1_resp_addr", 64'(dc_resp_addr), 64'h100);
    chk("t1_resp_data", dc_resp_data, 64'hDEAD);
    chk("t1_ic_resp", 64'(ic_resp_valid), 0);
    cyc(); idle(); #1;
    chk("t1_stray", 64'(stray_tag_err), 0);
    // 2: store beats ic load; store allocates nothing
    dc(BUS_STORE, 32'h200, 64'h55); ic_req_valid = 1'b1; ic_req_addr = 32'h300; mem2proc_response = 4'd5; #1;
    chk("t2_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("t2_addr", 64'(proc2mem_addr), 64'h200);
    chk("t2_data", proc2mem_data, 64'h55);
    chk("t2_dc_ready", 64'(dc_req_ready), 1);
    chk("t2_ic_ready", 64'(ic_req_ready), 0);
    cyc(); idle(); mem2proc_tag = 4'd5; #1;
    chk("t2_no_dc_resp", 64'(dc_resp_valid), 0);
    chk("t2_no_ic_resp", 64'(ic_resp_valid), 0);
    cyc(); idle(); #1;
    chk("t2_stray", 64'(stray_tag_err), 1);
    reset = 1'b1; #1;
    chk("t2_reset_stray", 64'(stray_tag_err), 0);
    reset = 1'b0;
    cyc();
    // 3: dc loads every cycle; ic forced on the 9th
    for (int k = 0; k < 9; k++) begin
      dc(BUS_LOAD, 32'(32'h1000 + 8 * k), 0); ic_req_valid = 1'b1; ic_req_addr = 32'h4000;
      mem2proc_response = 4'(k + 1); #1;
      chk("t3_dc_ready", 64'(dc_req_ready), 64'(k < 8));
      chk("t3_ic_ready", 64'(ic_req_ready), 64'(k == 8));
      cyc();
    end
    mem2proc_response = 4'd0; #1;
    chk("t3_starve_cleared_addr", 64'(proc2mem_addr), 64'h1040);
    chk("t3_starve_cleared_ic", 64'(ic_req_ready), 0);
    cyc(); idle();
    // 4: fill to 15 outstanding, loads blocked, stores still go, a return frees a slot
    for (int k = 0; k < 6; k++) begin
      dc(BUS_LOAD, 32'(32'h2000 + 8 * k), 0); mem2proc_response = 4'(10 + k); #1;
      chk("t4_fill_ready", 64'(dc_req_ready), 1);
      cyc();
    end
    dc(BUS_LOAD, 32'h3000, 0); mem2proc_response = 4'd1; #1;
    chk("t4_full_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("t4_full_ready", 64'(dc_req_ready), 0);
    cyc();
    dc(BUS_STORE, 32'h3008, 64'h99); mem2proc_response = 4'd2; #1;
    chk("t4_store_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("t4_store_ready", 64'(dc_req_ready), 1);
    cyc();
    dc(BUS_LOAD, 32'h3000, 0); mem2proc_response = 4'd0; mem2proc_tag = 4'd7; mem2proc_data = 64'h77; #1;
    chk("t4_ret7_valid", 64'(dc_resp_valid), 1);
    chk("t4_ret7_addr", 64'(dc_resp_addr), 64'h1030);
    chk("t4_ret7_data", dc_resp_data, 64'h77);
    chk("t4_ret7_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    cyc();
    mem2proc_tag = 4'd0; mem2proc_response = 4'd7; #1;
    chk("t4_slot_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("t4_slot_ready", 64'(dc_req_ready), 1);
    cyc(); idle();
    mem2proc_tag = 4'd9; mem2proc_data = 64'h99; #1;
    chk("t4_ic_resp", 64'(ic_resp_valid), 1);
    chk("t4_ic_addr", 64'(ic_resp_addr), 64'h4000);
    chk("t4_ic_data", ic_resp_data, 64'h99);
    chk("t4_ic_not_dc", 64'(dc_resp_valid), 0);
    cyc(); idle();
    // 5: return tag 4 while a new load is accepted on tag 4
    dc(BUS_LOAD, 32'h5000, 0); mem2proc_response = 4'd4; mem2proc_tag = 4'd4; mem2proc_data = 64'h44; #1;
    chk("t5_old_valid", 64'(dc_resp_valid), 1);
    chk("t5_old_addr", 64'(dc_resp_addr), 64'h1018);
    chk("t5_ready", 64'(dc_req_ready), 1);
    cyc(); idle(); #1;
    chk("t5_no_stray", 64'(stray_tag_err), 0);
    mem2proc_tag = 4'd4; mem2proc_data = 64'h45; #1;
    chk("t5_new_valid", 64'(dc_resp_valid), 1);
    chk("t5_new_addr", 64'(dc_resp_addr), 64'h5000);
    cyc(); idle(); #1;
    chk("t5_stray_after", 64'(stray_tag_err), 0);
    // 6: reset drops entries; late and unknown tags raise stray only
    reset = 1'b1; #1;
    chk("t6_rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    reset = 1'b0;
    cyc();
    mem2proc_tag = 4'd3; #1;
    chk("t6_late_dc", 64'(dc_resp_valid), 0);
    chk("t6_late_ic", 64'(ic_resp_valid), 0);
    cyc(); idle(); #1;
    chk("t6_late_stray", 64'(stray_tag_err), 1);
    reset = 1'b1; #1; reset = 1'b0;
    cyc();
    mem2proc_tag = 4'd9; #1;
    chk("t6_tag9_dc", 64'(dc_resp_valid), 0);
    chk("t6_tag9_ic", 64'(ic_resp_valid), 0);
    cyc(); idle(); #1;
    chk("t6_tag9_stray", 64'(stray_tag_err), 1);
    #2 reset = 1'b1; #1;
    chk("t6_async_clear", 64'(stray_tag_err), 0);
    reset = 1'b0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
